// File: rtl/ct_idu_id_split_fence_seq_pkg.sv
// Shared constants and state encoding for the ID-stage split/fence sequencer.
// Default geometry matches a 3-wide decode with 3-uop AMO expansion.
package ct_idu_seq_pkg;

    localparam int unsigned LANES      = 3;
    localparam int unsigned SPLIT_UOPS = 3;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned INST_W     = 32;

    // Fence-type bit positions in the per-lane 3-bit type field
    localparam int unsigned FT_BAR  = 0;
    localparam int unsigned FT_CP0  = 1;
    localparam int unsigned FT_CSRX = 2;

    // CP0/csrxchg fences keep younger lanes parked until the backend drains again
    localparam logic [2:0] FT_HOLD_MASK = (3'b1 << FT_CP0) | (3'b1 << FT_CSRX);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FWAIT = 2'd1;
    localparam logic [1:0] ST_FPOST = 2'd2;

    typedef enum logic [1:0] {
        RUN   = ST_RUN,
        FWAIT = ST_FWAIT,
        FPOST = ST_FPOST
    } seq_state_e;

endpackage

// File: rtl/ct_idu_id_split_fence_seq_if.sv
// Decoder-to-sequencer-to-IR signal bundle; the sequencer is the slave side.
interface ct_idu_id_split_fence_seq_if
    import ct_idu_seq_pkg::*;
#(
    parameter int unsigned LANES  = ct_idu_seq_pkg::LANES,
    parameter int unsigned IDX_W  = ct_idu_seq_pkg::IDX_W,
    parameter int unsigned INST_W = ct_idu_seq_pkg::INST_W
) ();

    logic                      id_bundle_vld;
    logic [LANES-1:0]          id_lane_vld;
    logic [LANES*INST_W-1:0]   id_inst;
    logic [LANES-1:0]          id_split;
    logic [LANES-1:0]          id_fence;
    logic [LANES*3-1:0]        id_fence_type;
    logic                      seq_id_ready;
    logic [LANES-1:0]          seq_ir_vld;
    logic [LANES*INST_W-1:0]   seq_ir_inst;
    logic [LANES*IDX_W-1:0]    seq_ir_split_idx;
    logic [LANES-1:0]          seq_ir_split_last;
    logic [LANES-1:0]          seq_ir_fence;
    logic                      ir_seq_stall;
    logic                      rtu_idu_pipe_empty;
    logic                      rtu_idu_flush;
    logic                      seq_fence_busy;

    modport master (
        output id_bundle_vld, id_lane_vld, id_inst, id_split, id_fence, id_fence_type,
        output ir_seq_stall, rtu_idu_pipe_empty, rtu_idu_flush,
        input  seq_id_ready, seq_ir_vld, seq_ir_inst, seq_ir_split_idx,
        input  seq_ir_split_last, seq_ir_fence, seq_fence_busy
    );

    modport slave (
        input  id_bundle_vld, id_lane_vld, id_inst, id_split, id_fence, id_fence_type,
        input  ir_seq_stall, rtu_idu_pipe_empty, rtu_idu_flush,
        output seq_id_ready, seq_ir_vld, seq_ir_inst, seq_ir_split_idx,
        output seq_ir_split_last, seq_ir_fence, seq_fence_busy
    );

endinterface

// File: rtl/ct_idu_id_split_fence_seq_lane_pick.sv
// Finds the first split/fence lane at or above ptr and shifts lanes ptr.. down to lane 0,
// keeping only the plain lanes that precede that special lane.
module ct_idu_seq_lane_pick #(
    parameter int unsigned LANES  = 3,
    parameter int unsigned INST_W = 32,
    parameter int unsigned PTR_W  = 2
) (
    input  logic [LANES-1:0]        lane_vld,
    input  logic [LANES-1:0]        special,
    input  logic [PTR_W-1:0]        ptr,
    input  logic [LANES*INST_W-1:0] inst,
    output logic                    found,
    output logic [PTR_W-1:0]        k,
    output logic [LANES-1:0]        cmp_vld,
    output logic [LANES*INST_W-1:0] cmp_inst
);

    logic [LANES-1:0] cand;
    logic [LANES-1:0] vld_sh;
    logic [PTR_W-1:0] lim;

    assign cand     = lane_vld & special & ({LANES{1'b1}} << ptr);
    assign vld_sh   = lane_vld >> ptr;
    assign cmp_inst = inst >> (ptr * INST_W);

    always_comb begin
        found = 1'b0;
        k     = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (!found && cand[i]) begin
                found = 1'b1;
                k     = PTR_W'(i);
            end
        end
    end

    // Emission stops just short of the special lane; without one, everything left goes
    always_comb begin
        lim = found ? (k - ptr) : PTR_W'(LANES);
        for (int unsigned j = 0; j < LANES; j++) begin
            cmp_vld[j] = vld_sh[j] && (PTR_W'(j) < lim);
        end
    end

endmodule

// File: rtl/ct_idu_id_split_fence_seq.sv
// ID-stage sequencer: holds one decoded bundle and releases it in order, expanding
// split-long instructions into uops and serialising fences against pipeline drain.
module ct_idu_id_split_fence_seq
    import ct_idu_seq_pkg::*;
#(
    parameter int unsigned LANES      = ct_idu_seq_pkg::LANES,
    parameter int unsigned SPLIT_UOPS = ct_idu_seq_pkg::SPLIT_UOPS,
    parameter int unsigned IDX_W      = ct_idu_seq_pkg::IDX_W,
    parameter int unsigned INST_W     = ct_idu_seq_pkg::INST_W
) (
    input  logic                          forever_cpuclk,
    input  logic                          cpurst,
    ct_idu_id_split_fence_seq_if.slave    seq_if
);

    localparam int unsigned PTR_W = $clog2(LANES + 1);

    logic                      held_vld;
    logic [LANES-1:0]          h_lane_vld;
    logic [LANES*INST_W-1:0]   h_inst;
    logic [LANES-1:0]          h_split;
    logic [LANES-1:0]          h_fence;
    logic [LANES*3-1:0]        h_ftype;
    logic [PTR_W-1:0]          ptr;
    logic [IDX_W-1:0]          idx;
    seq_state_e                state;
    logic                      fpost_first;

    logic                      found;
    logic [PTR_W-1:0]          k;
    logic [LANES-1:0]          cmp_vld;
    logic [LANES*INST_W-1:0]   cmp_inst;

    logic                      cur_split;
    logic                      cur_fence;
    logic                      nxt_lane_vld;
    logic [2:0]                cur_ftype;
    logic                      out_en;
    logic                      accept;

    logic [LANES-1:0]          emit_vld;
    logic [IDX_W-1:0]          emit_idx;
    logic [LANES-1:0]          emit_last;
    logic                      emit_fence;
    logic                      step;
    logic                      nxt_held;
    logic [PTR_W-1:0]          nxt_ptr;
    logic [IDX_W-1:0]          nxt_idx;
    seq_state_e                nxt_state;
    logic                      nxt_fpost_first;

    ct_idu_seq_lane_pick #(
        .LANES  (LANES),
        .INST_W (INST_W),
        .PTR_W  (PTR_W)
    ) u_lane_pick (
        .lane_vld (h_lane_vld),
        .special  (h_split | h_fence),
        .ptr      (ptr),
        .inst     (h_inst),
        .found    (found),
        .k        (k),
        .cmp_vld  (cmp_vld),
        .cmp_inst (cmp_inst)
    );

    assign cur_split    = |(h_split & h_lane_vld & (LANES'(1) << ptr));
    assign cur_fence    = |(h_fence & h_lane_vld & (LANES'(1) << ptr));
    assign nxt_lane_vld = |(h_lane_vld & (LANES'(1) << (ptr + PTR_W'(1))));

    always_comb begin
        cur_ftype = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (PTR_W'(i) == ptr) cur_ftype = h_ftype[i*3 +: 3];
        end
    end

    always_comb begin
        emit_vld        = '0;
        emit_idx        = '0;
        emit_last       = '0;
        emit_fence      = 1'b0;
        step            = 1'b0;
        nxt_held        = held_vld;
        nxt_ptr         = ptr;
        nxt_idx         = idx;
        nxt_state       = state;
        nxt_fpost_first = 1'b0;
        if (held_vld) begin
            case (state)
                RUN: begin
                    if (cur_fence) begin
                        nxt_state = FWAIT;
                    end else if (cur_split) begin
                        emit_vld = LANES'(1);
                        emit_idx = idx;
                        if (idx == IDX_W'(SPLIT_UOPS - 1)) begin
                            emit_last = LANES'(1);
                            nxt_idx   = '0;
                            step      = 1'b1;
                        end else begin
                            nxt_idx = idx + IDX_W'(1);
                        end
                    end else if (found) begin
                        emit_vld  = cmp_vld;
                        emit_last = cmp_vld;
                        nxt_ptr   = k;
                    end else begin
                        emit_vld  = cmp_vld;
                        emit_last = cmp_vld;
                        nxt_held  = 1'b0;
                        nxt_ptr   = '0;
                    end
                end
                FWAIT: begin
                    if (seq_if.rtu_idu_pipe_empty) begin
                        emit_vld   = LANES'(1);
                        emit_last  = LANES'(1);
                        emit_fence = 1'b1;
                        if (|(cur_ftype & FT_HOLD_MASK)) begin
                            nxt_state       = FPOST;
                            nxt_fpost_first = 1'b1;
                        end else begin
                            nxt_state = RUN;
                            step      = 1'b1;
                        end
                    end
                end
                FPOST: begin
                    // The drain seen in the fence's own issue cycle is stale, so skip one cycle
                    if (!fpost_first && seq_if.rtu_idu_pipe_empty) begin
                        nxt_state = RUN;
                        step      = 1'b1;
                    end
                end
                default: nxt_state = RUN;
            endcase
        end
        if (step) begin
            if (nxt_lane_vld) begin
                nxt_ptr = ptr + PTR_W'(1);
            end else begin
                nxt_ptr  = '0;
                nxt_held = 1'b0;
            end
        end
    end

    assign out_en = !cpurst && !seq_if.rtu_idu_flush;
    assign seq_if.seq_id_ready   = out_en && !held_vld;
    assign accept                = seq_if.id_bundle_vld && seq_if.seq_id_ready;
    assign seq_if.seq_fence_busy = !cpurst && (state == FWAIT || state == FPOST);

    always_comb begin
        seq_if.seq_ir_vld        = out_en ? emit_vld : '0;
        seq_if.seq_ir_split_last = out_en ? emit_last : '0;
        seq_if.seq_ir_fence      = (out_en && emit_fence) ? LANES'(1) : '0;
        seq_if.seq_ir_split_idx  = out_en ? (LANES*IDX_W)'(emit_idx) : '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            seq_if.seq_ir_inst[j*INST_W +: INST_W] =
                (out_en && emit_vld[j]) ? cmp_inst[j*INST_W +: INST_W] : '0;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            held_vld    <= 1'b0;
            ptr         <= '0;
            idx         <= '0;
            state       <= RUN;
            fpost_first <= 1'b0;
            h_lane_vld  <= '0;
            h_inst      <= '0;
            h_split     <= '0;
            h_fence     <= '0;
            h_ftype     <= '0;
        end else if (seq_if.rtu_idu_flush) begin
            held_vld    <= 1'b0;
            ptr         <= '0;
            idx         <= '0;
            state       <= RUN;
            fpost_first <= 1'b0;
        end else begin
            if (!seq_if.ir_seq_stall) begin
                held_vld    <= nxt_held;
                ptr         <= nxt_ptr;
                idx         <= nxt_idx;
                state       <= nxt_state;
                fpost_first <= nxt_fpost_first;
            end
            if (accept) begin
                held_vld   <= 1'b1;
                ptr        <= '0;
                idx        <= '0;
                h_lane_vld <= seq_if.id_lane_vld;
                h_inst     <= seq_if.id_inst;
                h_split    <= seq_if.id_split;
                h_fence    <= seq_if.id_fence;
                h_ftype    <= seq_if.id_fence_type;
            end
        end
    end

endmodule

// File: tb/tb_ct_idu_id_split_fence_seq.sv
// Directed bench for the ID-stage split/fence sequencer with hand-computed expectations.
module tb_ct_idu_id_split_fence_seq;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ct_idu_id_split_fence_seq_if sif ();

    ct_idu_id_split_fence_seq dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .seq_if         (sif)
    );

    task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic nxt();
        cyc();
        #1;
    endtask

    task automatic exp_out(input string tag, input logic [2:0] v,
                           input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] l2,
                           input logic [1:0] ix0, input logic [2:0] lst, input logic [2:0] fc,
                           input logic bsy, input logic rdy);
        logic [31:0] e [3];
        e[0] = l0; e[1] = l1; e[2] = l2;
        chk({tag, ".vld"}, 96'(sif.seq_ir_vld), 96'(v));
        for (int j = 0; j < 3; j++) begin
            if (v[j]) chk({tag, ".inst"}, 96'(sif.seq_ir_inst[j*32 +: 32]), 96'(e[j]));
        end
        if (v[0]) chk({tag, ".idx"}, 96'(sif.seq_ir_split_idx[1:0]), 96'(ix0));
        chk({tag, ".last"}, 96'(sif.seq_ir_split_last & v), 96'(lst));
        chk({tag, ".fence"}, 96'(sif.seq_ir_fence & v), 96'(fc));
        chk({tag, ".busy"}, 96'(sif.seq_fence_busy), 96'(bsy));
        chk({tag, ".ready"}, 96'(sif.seq_id_ready), 96'(rdy));
    endtask

    task automatic offer(input logic [2:0] lv, input logic [31:0] i0, input logic [31:0] i1,
                         input logic [31:0] i2, input logic [2:0] sp, input logic [2:0] fe,
                         input logic [8:0] ft);
        sif.id_lane_vld   = lv;
        sif.id_inst       = {i2, i1, i0};
        sif.id_split      = sp;
        sif.id_fence      = fe;
        sif.id_fence_type = ft;
        sif.id_bundle_vld = 1'b1;
        #1;
        chk("offer.ready", 96'(sif.seq_id_ready), 96'(1));
        cyc();
        sif.id_bundle_vld = 1'b0;
        #1;
    endtask

    initial begin
        rst                    = 1'b1;
        sif.id_bundle_vld      = 1'b0;
        sif.id_lane_vld        = '0;
        sif.id_inst            = '0;
        sif.id_split           = '0;
        sif.id_fence           = '0;
        sif.id_fence_type      = '0;
        sif.ir_seq_stall       = 1'b0;
        sif.rtu_idu_pipe_empty = 1'b1;
        sif.rtu_idu_flush      = 1'b0;

        cyc(); cyc();
        chk("rst.ready", 96'(sif.seq_id_ready), 96'(0));
        chk("rst.vld",   96'(sif.seq_ir_vld), 96'(0));
        chk("rst.inst",  96'(sif.seq_ir_inst), 96'(0));
        chk("rst.idx",   96'(sif.seq_ir_split_idx), 96'(0));
        chk("rst.last",  96'(sif.seq_ir_split_last), 96'(0));
        chk("rst.fence", 96'(sif.seq_ir_fence), 96'(0));
        cyc();
        rst = 1'b0;
        #1;
        chk("post_rst.ready", 96'(sif.seq_id_ready), 96'(1));
        chk("post_rst.busy",  96'(sif.seq_fence_busy), 96'(0));

        // plain bundle goes out in one cycle
        offer(3'b111, 32'h11, 32'h12, 32'h13, 3'b000, 3'b000, 9'h0);
        exp_out("t1_emit", 3'b111, 32'h11, 32'h12, 32'h13, 2'd0, 3'b111, 3'b000, 1'b0, 1'b0);
        nxt();
        exp_out("t1_done", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000, 1'b0, 1'b1);

        // add, amadd.w (split), sub
        offer(3'b111, 32'hA0, 32'hA1, 32'hA2, 3'b010, 3'b000, 9'h0);
        exp_out("t2_add", 3'b001, 32'hA0, 0, 0, 2'd0, 3'b001, 3'b000, 1'b0, 1'b0);
        nxt();
        exp_out("t2_u0", 3'b001, 32'hA1, 0, 0, 2'd0, 3'b000, 3'b000, 1'b0, 1'b0);
        nxt();
        exp_out("t2_u1", 3'b001, 32'hA1, 0, 0, 2'd1, 3'b000, 3'b000, 1'b0, 1'b0);
        nxt();
        exp_out("t2_u2", 3'b001, 32'hA1, 0, 0, 2'd2, 3'b001, 3'b000, 1'b0, 1'b0);
        nxt();
        exp_out("t2_sub", 3'b001, 32'hA2, 0, 0, 2'd0, 3'b001, 3'b000, 1'b0, 1'b0);
        nxt();
        exp_out("t2_done", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000, 1'b0, 1'b1);

        // dbar waits for drain, then younger lanes follow
        sif.rtu_idu_pipe_empty = 1'b0;
        offer(3'b111, 32'hB0, 32'hB1, 32'hB2, 3'b000, 3'b001, 9'b000_000_001);
        exp_out("t3_run", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            nxt();
            exp_out("t3_wait", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000, 1'b1, 1'b0);
        end
        cyc();
        sif.rtu_idu_pipe_empty = 1'b1;
        #1;
        exp_out("t3_fence", 3'b001, 32'hB0, 0, 0, 2'd0, 3'b001, 3'b001, 1'b1, 1'b0);
        nxt();
        exp_out("t3_young", 3'b011, 32'hB1, 32'hB2, 0, 2'd0, 3'b011, 3'b000, 1'b0, 1'b0);
        nxt();
        exp_out("t3_done", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000, 1'b0, 1'b1);

        // csrwr holds add through FPOST; drain in the first FPOST cycle is ignored
        offer(3'b011, 32'hC0, 32'hC1, 0, 3'b000, 3'b001, 9'b000_000_010);
        exp_out("t4_run", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000, 1'b0, 1'b0);
        nxt();
        exp_out("t4_fence", 3'b001, 32'hC0, 0, 0, 2'd0, 3'b001, 3'b001, 1'b1, 1'b0);
        nxt();
        exp_out("t4_post1", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000, 1'b1, 1'b0);
        cyc();
        sif.rtu_idu_pipe_empty = 1'b0;
        #1;
        exp_out("t4_post2", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000, 1'b1, 1'b0);
        cyc();
        sif.rtu_idu_pipe_empty = 1'b1;
        #1;
        exp_out("t4_post3", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000, 1'b1, 1'b0);
        nxt();
        exp_out("t4_add", 3'b001, 32'hC1, 0, 0, 2'd0, 3'b001, 3'b000, 1'b0, 1'b0);
        nxt();
        exp_out("t4_done", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000, 1'b0, 1'b1);

        // stall mid-split at idx1
        offer(3'b001, 32'hD0, 0, 0, 3'b001, 3'b000, 9'h0);
        exp_out("t5_u0", 3'b001, 32'hD0, 0, 0, 2'd0, 3'b000, 3'b000, 1'b0, 1'b0);
        cyc();
        sif.ir_seq_stall = 1'b1;
        #1;
        exp_out("t5_u1", 3'b001, 32'hD0, 0, 0, 2'd1, 3'b000, 3'b000, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            nxt();
            exp_out("t5_stall", 3'b001, 32'hD0, 0, 0, 2'd1, 3'b000, 3'b000, 1'b0, 1'b0);
        end
        cyc();
        sif.ir_seq_stall = 1'b0;
        #1;
        exp_out("t5_resume", 3'b001, 32'hD0, 0, 0, 2'd1, 3'b000, 3'b000, 1'b0, 1'b0);
        nxt();
        exp_out("t5_u2", 3'b001, 32'hD0, 0, 0, 2'd2, 3'b001, 3'b000, 1'b0, 1'b0);
        nxt();
        exp_out("t5_done", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000, 1'b0, 1'b1);

        // flush in FWAIT beats a simultaneous offer
        sif.rtu_idu_pipe_empty = 1'b0;
        offer(3'b011, 32'hE0, 32'hE1, 0, 3'b000, 3'b001, 9'b000_000_001);
        exp_out("t6_run", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000, 1'b0, 1'b0);
        nxt();
        exp_out("t6_wait", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000, 1'b1, 1'b0);
        cyc();
        sif.rtu_idu_flush      = 1'b1;
        sif.rtu_idu_pipe_empty = 1'b1;
        sif.id_lane_vld        = 3'b001;
        sif.id_inst            = {32'h0, 32'h0, 32'hF0};
        sif.id_split           = '0;
        sif.id_fence           = '0;
        sif.id_fence_type      = '0;
        sif.id_bundle_vld      = 1'b1;
        #1;
        exp_out("t6_flush", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000, 1'b1, 1'b0);
        cyc();
        sif.rtu_idu_flush = 1'b0;
        sif.id_bundle_vld = 1'b0;
        #1;
        exp_out("t6_after", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000, 1'b0, 1'b1);
        nxt();
        exp_out("t6_noacc", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000, 1'b0, 1'b1);

        // empty bundle with stray flags is dropped silently
        offer(3'b000, 32'h77, 32'h78, 32'h79, 3'b111, 3'b111, 9'h1FF);
        exp_out("t7_drop", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000, 1'b0, 1'b0);
        nxt();
        exp_out("t7_done", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
